maquina_param: RTL and testbench
================================

MAQUINA_PARAM -- requirements
Module: maquina_param

Interface
REQ-001 SHALL have parameter N_PROD, default 4, number of products (1..8).
REQ-002 SHALL have parameter W, default 6, credit width in unit coins.
REQ-003 SHALL have parameter MAX_CREDIT, default 31, credit ceiling (< 2**W).
REQ-004 SHALL have parameter PRECIOS, default {7,5,3,2} (product 3..0), packed N_PROD*W, price of product i in bits [i*W +: W], each price >= 1.
REQ-005 SHALL have parameter STOCK_INIT, default 3, initial units per product, 4-bit.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 SHALL have ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- moneda  in  2  coin this cycle: 00 none, 01 = 1, 10 = 2, 11 = 5 units
- comprar  in  N_PROD  purchase request per product, level-sampled
- cancelar  in  1  refund request
- listo  out  N_PROD  product i purchasable now
- agotado  out  N_PROD  stock of product i is 0
- total  out  W  current credit
- dispensar  out  N_PROD  one-cycle pulse, product released
- cambio  out  1  one-cycle pulse, one unit coin returned
- rechazo  out  1  one-cycle pulse, inserted coin returned unaccepted
- ocupado  out  1  FSM not in IDLE

Function
REQ-008 SHALL implement a registered FSM with states IDLE, VEND, CAMBIO.
REQ-009 In IDLE, SHALL evaluate events in priority: cancelar > valid compra > moneda.
REQ-010 In IDLE with cancelar=1 and total>0, SHALL go to CAMBIO; with total=0, cancelar has no effect.
REQ-011 A compra is valid for product i when comprar[i]=1, total >= price[i] and stock[i] != 0; if several are valid, SHALL select the lowest index.
REQ-012 On a valid compra, SHALL latch the selected index and go to VEND.
REQ-013 In VEND (exactly one cycle), SHALL pulse dispensar[sel], decrement stock[sel] by 1 and subtract price[sel] from total, all at the end of that cycle.
REQ-014 On leaving VEND, SHALL go to CAMBIO if the new total > 0, else to IDLE.
REQ-015 In CAMBIO, SHALL assert cambio each cycle and decrement total by 1; on the cycle that total reaches 0, SHALL go to IDLE.
REQ-016 A coin in IDLE with no higher-priority event, where total + value <= MAX_CREDIT, SHALL add its value to total at the next edge.
REQ-017 Every other non-zero coin (over ceiling, same-cycle higher-priority event, or state VEND/CAMBIO) SHALL pulse rechazo on the next cycle and leave total unchanged.
REQ-018 comprar and cancelar outside IDLE SHALL be ignored.
REQ-019 listo[i] SHALL be 1 only when in IDLE, total >= price[i] and stock[i] != 0; it SHALL be combinational from registered state.
REQ-020 agotado[i] SHALL equal (stock[i] == 0); stock SHALL never wrap below 0.
REQ-021 ocupado SHALL equal (state != IDLE).
REQ-022 Arithmetic SHALL be unsigned W-bit with no overflow, guaranteed by REQ-016.

Reset
REQ-023 While reset=1 at an edge, SHALL force state IDLE, total=0, every stock=STOCK_INIT, and dispensar, cambio, rechazo=0; reset SHALL abort VEND/CAMBIO with no refund.
REQ-024 After reset, listo=0, agotado=0 (STOCK_INIT>0), ocupado=0.

Verification
REQ-025 Coins 10, 01 (3 units), then comprar=0100 -> listo=0011 before purchase, dispensar[2] never; comprar=0010 -> dispensar[1] pulse, total 0, back to IDLE, no cambio.
REQ-026 Coins 11, 10 (7), comprar=0001 -> dispensar[0], then 5 cambio pulses on consecutive cycles, total 5..0, ocupado high for 6 cycles.
REQ-027 Credit 30, coin 10 -> rechazo pulse, total stays 30; coin 01 -> total 31.
REQ-028 Buy product 0 three times (price 2 each) -> agotado[0]=1, listo[0]=0; fourth comprar=0001 with credit 4 -> no dispense.
REQ-029 Credit 5, same-cycle cancelar=1 + comprar=0001 + moneda=01 -> CAMBIO, 5 cambio pulses, rechazo pulse, no dispensar.
REQ-030 Coin during CAMBIO -> rechazo; reset asserted mid-CAMBIO -> total 0, state IDLE, stocks restored to 3.

Source files
------------

// File: rtl/maquina_param.sv
// maquina_param: parameterised vending machine controller.
// Accepts coins into a bounded credit register, dispenses the lowest-index
// requested product that is affordable and in stock, then refunds any
// remaining credit one unit per cycle. Cancel refunds the whole credit.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   moneda     coin this cycle: 00 none, 01 = 1, 10 = 2, 11 = 5 units
//   comprar    per-product purchase request (level-sampled)
//   cancelar   refund request
//   listo      product i purchasable now
//   agotado    product i out of stock
//   total      current credit
//   dispensar  one-cycle pulse, product released
//   cambio     one-cycle pulse, one unit coin returned
//   rechazo    one-cycle pulse, inserted coin returned unaccepted
//   ocupado    machine busy (not idle)
module maquina_param #(
  parameter int                  N_PROD     = 4,
  parameter int                  W          = 6,
  parameter int                  MAX_CREDIT = 31,
  parameter logic [N_PROD*W-1:0] PRECIOS    = {6'd7, 6'd5, 6'd3, 6'd2},
  parameter logic [3:0]          STOCK_INIT = 4'd3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        moneda,
  input  logic [N_PROD-1:0] comprar,
  input  logic              cancelar,
  output logic [N_PROD-1:0] listo,
  output logic [N_PROD-1:0] agotado,
  output logic [W-1:0]      total,
  output logic [N_PROD-1:0] dispensar,
  output logic              cambio,
  output logic              rechazo,
  output logic              ocupado
);

  localparam int SW = (N_PROD > 1) ? $clog2(N_PROD) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CAMBIO = 2'd2
  } state_t;

  function automatic logic [W-1:0] price_of(input int idx);
    return PRECIOS[idx*W +: W];
  endfunction

  function automatic logic [2:0] coin_val(input logic [1:0] m);
    logic [2:0] v;
    case (m)
      2'b01:   v = 3'd1;
      2'b10:   v = 3'd2;
      2'b11:   v = 3'd5;
      default: v = 3'd0;
    endcase
    return v;
  endfunction

  state_t                  state_r, state_s;
  logic [W-1:0]            total_r, total_s;
  logic [N_PROD-1:0][3:0]  stock_r, stock_s;
  logic [SW-1:0]           sel_r, sel_s;
  logic [N_PROD-1:0]       dispensar_r, dispensar_s;
  logic                    cambio_r, cambio_s;
  logic                    rechazo_r, rechazo_s;

  logic [N_PROD-1:0]       listo_s;
  logic [N_PROD-1:0]       valid_s;
  logic [N_PROD-1:0]       onehot_s;
  logic [SW-1:0]           pick_s;
  logic [W:0]              sum_s;
  logic                    coin_nz_s;
  logic                    cancel_ev_s;

  // Availability per product, purchase qualification and lowest-index pick.
  always_comb begin
    pick_s   = '0;
    onehot_s = '0;
    for (int i = 0; i < N_PROD; i++) begin
      listo_s[i]   = (state_r == IDLE) && (total_r >= price_of(i)) && (stock_r[i] != 4'd0);
      valid_s[i]   = listo_s[i] && comprar[i];
      agotado[i]   = (stock_r[i] == 4'd0);
    end
    // Scan downward so the lowest valid index wins.
    for (int i = N_PROD - 1; i >= 0; i--) begin
      pick_s = valid_s[i] ? SW'(i) : pick_s;
    end
    for (int i = 0; i < N_PROD; i++) begin
      onehot_s[i] = (pick_s == SW'(i));
    end
  end

  assign coin_nz_s   = (moneda != 2'b00);
  // Sum is one bit wider so the ceiling test cannot overflow.
  assign sum_s       = (W+1)'(total_r) + (W+1)'(coin_val(moneda));
  // Cancel with zero credit is not an event at all.
  assign cancel_ev_s = cancelar && (total_r != '0);

  // Next-state and next-output logic for the vending FSM.
  always_comb begin
    state_s     = state_r;
    total_s     = total_r;
    stock_s     = stock_r;
    sel_s       = sel_r;
    dispensar_s = '0;
    cambio_s    = 1'b0;
    rechazo_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (cancel_ev_s) begin
          state_s   = CAMBIO;
          cambio_s  = 1'b1;
          rechazo_s = coin_nz_s;
        end else if (|valid_s) begin
          state_s     = VEND;
          sel_s       = pick_s;
          dispensar_s = onehot_s;
          rechazo_s   = coin_nz_s;
        end else if (coin_nz_s && (sum_s <= (W+1)'(MAX_CREDIT))) begin
          total_s = sum_s[W-1:0];
        end else begin
          rechazo_s = coin_nz_s;
        end
      end
      VEND: begin
        rechazo_s = coin_nz_s;
        total_s   = total_r - price_of(int'(sel_r));
        if (stock_r[sel_r] != 4'd0) begin
          stock_s[sel_r] = stock_r[sel_r] - 4'd1;
        end else begin
          stock_s[sel_r] = 4'd0;
        end
        if (total_s != '0) begin
          state_s  = CAMBIO;
          cambio_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      CAMBIO: begin
        rechazo_s = coin_nz_s;
        if (total_r > W'(1)) begin
          total_s  = total_r - W'(1);
          cambio_s = 1'b1;
        end else begin
          total_s = '0;
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      total_r     <= '0;
      stock_r     <= {N_PROD{STOCK_INIT}};
      sel_r       <= '0;
      dispensar_r <= '0;
      cambio_r    <= 1'b0;
      rechazo_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      total_r     <= total_s;
      stock_r     <= stock_s;
      sel_r       <= sel_s;
      dispensar_r <= dispensar_s;
      cambio_r    <= cambio_s;
      rechazo_r   <= rechazo_s;
    end
  end

  assign listo     = listo_s;
  assign total     = total_r;
  assign dispensar = dispensar_r;
  assign cambio    = cambio_r;
  assign rechazo   = rechazo_r;
  assign ocupado   = (state_r != IDLE);

endmodule

// File: tb/tb_maquina_param.sv
// Self-checking bench for maquina_param (default parameters).
// A transaction-level model tracks credit and stock; each purchase or cancel
// expands into a queue of expected busy cycles (one vend cycle, then one
// refund cycle per remaining credit unit).
module tb_maquina_param;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] moneda;
  logic [3:0] comprar;
  logic       cancelar;
  logic [3:0] listo, agotado, dispensar;
  logic [5:0] total;
  logic       cambio, rechazo, ocupado;

  maquina_param dut (
    .clk(clk), .reset(reset), .moneda(moneda), .comprar(comprar),
    .cancelar(cancelar), .listo(listo), .agotado(agotado), .total(total),
    .dispensar(dispensar), .cambio(cambio), .rechazo(rechazo), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit run_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0] disp;
    logic       camb;
    int         tot;
  } rec_t;

  rec_t q[$];
  int   credit;
  int   stk[4];
  int   price[4] = '{2, 3, 5, 7};
  logic rej_m;

  function automatic int coinv(input logic [1:0] m);
    return (m == 2'b01) ? 1 : (m == 2'b10) ? 2 : (m == 2'b11) ? 5 : 0;
  endfunction

  task automatic push_refund(input int from);
    rec_t r;
    for (int k = from; k >= 1; k--) begin
      r.disp = 4'b0; r.camb = 1'b1; r.tot = k;
      q.push_back(r);
    end
  endtask

  always @(posedge clk) begin
    int cv, p;
    rec_t r;
    if (reset) begin
      q.delete();
      credit = 0;
      for (int i = 0; i < 4; i++) stk[i] = 3;
      rej_m = 1'b0;
    end else if (q.size() > 0) begin
      rej_m = (moneda != 2'b00);
      for (int i = 0; i < 4; i++) if (q[0].disp[i]) stk[i] = stk[i] - 1;
      void'(q.pop_front());
    end else begin
      cv = coinv(moneda);
      p  = -1;
      for (int i = 3; i >= 0; i--)
        if (comprar[i] && credit >= price[i] && stk[i] > 0) p = i;
      if (cancelar && credit > 0) begin
        push_refund(credit);
        credit = 0;
        rej_m  = (cv != 0);
      end else if (p >= 0) begin
        r.disp = 4'b0001 << p; r.camb = 1'b0; r.tot = credit;
        q.push_back(r);
        push_refund(credit - price[p]);
        credit = 0;
        rej_m  = (cv != 0);
      end else if (cv != 0 && credit + cv <= 31) begin
        credit = credit + cv;
        rej_m  = 1'b0;
      end else begin
        rej_m = (cv != 0);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [3:0] e_listo, e_agot, e_disp;
    logic       e_camb, e_ocup;
    int         e_tot;
    if (run_chk) begin
      for (int i = 0; i < 4; i++) e_agot[i] = (stk[i] == 0);
      if (q.size() > 0) begin
        e_ocup = 1'b1; e_disp = q[0].disp; e_camb = q[0].camb; e_tot = q[0].tot;
        e_listo = 4'b0;
      end else begin
        e_ocup = 1'b0; e_disp = 4'b0; e_camb = 1'b0; e_tot = credit;
        for (int i = 0; i < 4; i++) e_listo[i] = (credit >= price[i]) && (stk[i] > 0);
      end
      chk("ocupado",   32'(ocupado),   32'(e_ocup));
      chk("dispensar", 32'(dispensar), 32'(e_disp));
      chk("cambio",    32'(cambio),    32'(e_camb));
      chk("total",     32'(total),     32'(e_tot));
      chk("listo",     32'(listo),     32'(e_listo));
      chk("agotado",   32'(agotado),   32'(e_agot));
      chk("rechazo",   32'(rechazo),   32'(rej_m));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [1:0] m, input logic [3:0] c, input logic k);
    moneda = m; comprar = c; cancelar = k;
    @(posedge clk);
    #1;
    moneda = 2'b00; comprar = 4'b0; cancelar = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2'b00, 4'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; moneda = 2'b00; comprar = 4'b0; cancelar = 1'b0;
    step(2'b00, 4'b0, 1'b0);
    step(2'b00, 4'b0, 1'b0);
    reset = 1'b0;
    run_chk = 1'b1;
    chk("rst_listo",   32'(listo),   32'h0);
    chk("rst_agotado", 32'(agotado), 32'h0);
    chk("rst_ocupado", 32'(ocupado), 32'h0);
    chk("rst_total",   32'(total),   32'h0);

    // Credit 3: only products 0 and 1 affordable; product 2 request ignored.
    step(2'b10, 4'b0, 1'b0);
    step(2'b01, 4'b0, 1'b0);
    chk("r25_listo", 32'(listo), 32'h3);
    step(2'b00, 4'b0100, 1'b0);
    chk("r25_nodisp", 32'(dispensar), 32'h0);
    chk("r25_total3", 32'(total), 32'd3);
    step(2'b00, 4'b0010, 1'b0);
    chk("r25_disp1", 32'(dispensar), 32'h2);
    step(2'b00, 4'b0, 1'b0);
    chk("r25_total0", 32'(total), 32'd0);
    chk("r25_idle",   32'(ocupado), 32'd0);
    chk("r25_nocamb", 32'(cambio), 32'd0);

    // Credit 7, buy product 0, five refund pulses.
    step(2'b11, 4'b0, 1'b0);
    step(2'b10, 4'b0, 1'b0);
    step(2'b00, 4'b0001, 1'b0);
    chk("r26_disp0", 32'(dispensar), 32'h1);
    chk("r26_busy",  32'(ocupado), 32'd1);
    for (int k = 5; k >= 1; k--) begin
      step(2'b00, 4'b0, 1'b0);
      chk("r26_total", 32'(total), 32'(k));
      chk("r26_camb",  32'(cambio), 32'd1);
      chk("r26_busyc", 32'(ocupado), 32'd1);
    end
    step(2'b00, 4'b0, 1'b0);
    chk("r26_done", 32'(ocupado), 32'd0);
    chk("r26_tot0", 32'(total), 32'd0);

    // Ceiling: 30 + 2 rejected, 30 + 1 accepted.
    for (int i = 0; i < 6; i++) step(2'b11, 4'b0, 1'b0);
    chk("r27_total30", 32'(total), 32'd30);
    step(2'b10, 4'b0, 1'b0);
    chk("r27_rech", 32'(rechazo), 32'd1);
    chk("r27_keep", 32'(total), 32'd30);
    step(2'b01, 4'b0, 1'b0);
    chk("r27_total31", 32'(total), 32'd31);
    chk("r27_norech", 32'(rechazo), 32'd0);
    step(2'b00, 4'b0, 1'b1);
    for (int i = 0; i < 32; i++) step(2'b00, 4'b0, 1'b0);
    chk("r27_drained", 32'(total), 32'd0);

    // Exhaust product 0.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(2'b10, 4'b0, 1'b0);
      step(2'b00, 4'b0001, 1'b0);
      step(2'b00, 4'b0, 1'b0);
    end
    chk("r28_agot", 32'(agotado), 32'h1);
    step(2'b10, 4'b0, 1'b0);
    step(2'b10, 4'b0, 1'b0);
    chk("r28_listo", 32'(listo), 32'h2);
    step(2'b00, 4'b0001, 1'b0);
    chk("r28_nodisp", 32'(dispensar), 32'h0);
    chk("r28_idle",   32'(ocupado), 32'd0);
    chk("r28_total",  32'(total), 32'd4);
    step(2'b00, 4'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(2'b00, 4'b0, 1'b0);

    // Cancel beats purchase and coin in the same cycle.
    step(2'b11, 4'b0, 1'b0);
    step(2'b01, 4'b0001, 1'b1);
    chk("r29_camb",   32'(cambio), 32'd1);
    chk("r29_rech",   32'(rechazo), 32'd1);
    chk("r29_nodisp", 32'(dispensar), 32'h0);
    chk("r29_total",  32'(total), 32'd5);
    for (int i = 0; i < 5; i++) step(2'b00, 4'b0, 1'b0);
    chk("r29_idle", 32'(ocupado), 32'd0);

    // Coin during refund is rejected; reset mid-refund restores stocks.
    step(2'b11, 4'b0, 1'b0);
    step(2'b00, 4'b0, 1'b1);
    step(2'b01, 4'b0, 1'b0);
    chk("r30_rech",  32'(rechazo), 32'd1);
    chk("r30_total", 32'(total), 32'd4);
    do_reset();
    chk("r30_total0", 32'(total), 32'd0);
    chk("r30_idle",   32'(ocupado), 32'd0);
    chk("r30_agot",   32'(agotado), 32'h0);
    chk("r30_camb",   32'(cambio), 32'd0);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] m;
      logic [3:0] cm;
      logic       k;
      m  = ($urandom_range(0, 9) < 4) ? 2'b00 : 2'($urandom_range(1, 3));
      cm = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      k  = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 299) == 0);
      step(m, cm, k);
      reset = 1'b0;
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
